// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scan driver.
// Shows the number under test in hex, a busy dash pattern,
// and the prime result on digit 0's decimal point.
//
// Ports:
//   clk_in   - system clock (only clock, rising edge)
//   rst      - asynchronous active-high reset
//   scan_clk - divider square wave, sampled as async data
//   value    - 4*DIGITS number, nibble i -> digit i (0 = rightmost)
//   load     - strobe: capture value, clear result flag
//   busy     - level: test in progress (dash on all digits)
//   done     - strobe: result valid, sample is_prime
//   is_prime - test result
//   an       - one-hot digit enables
//   seg      - segments, bit0 = a .. bit6 = g
//   dp       - decimal point
module seg_scan_display #(
    parameter int DIGITS         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  busy,
    input  logic                  done,
    input  logic                  is_prime,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [2:0]          sync;
    logic                tick;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] frame;
    logic                res_valid;
    logic                res_prime;
    logic [IW-1:0]       idx;
    logic                started;

    logic [IW-1:0]       next_idx;
    logic [4*DIGITS-1:0] next_frame;
    logic [4*DIGITS-1:0] upper;
    logic [6:0]          seg_hi;
    logic                dp_hi;
    logic [DIGITS-1:0]   an_hi;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

    // sync[1] is the second synchroniser stage, sync[2] the edge-detect flop
    assign tick = sync[1] & ~sync[2];

    always_comb begin
        next_idx = '0;
        if (started && idx != LAST)
            next_idx = idx + IW'(1);
    end

    // Frame only refreshes at the wrap, so a scan never mixes two values
    assign next_frame = (next_idx == '0) ? shadow : frame;

    // Upper holds nibbles i..DIGITS-1; zero means a leading zero
    assign upper = next_frame >> (4 * int'(next_idx));

    always_comb begin
        seg_hi = glyph(upper[3:0]);
        if (busy)
            seg_hi = 7'b1000000;
        else if (BLANK_LZ && next_idx != '0 && upper == '0)
            seg_hi = 7'b0000000;
        dp_hi = (next_idx == '0) && res_valid && res_prime && !busy;
        an_hi = DIGITS'(1) << next_idx;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            shadow    <= '0;
            frame     <= '0;
            res_valid <= 1'b0;
            res_prime <= 1'b0;
            idx       <= '0;
            started   <= 1'b0;
            an        <= {DIGITS{SEG_ACTIVE_LOW}};
            seg       <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
        end else begin
            sync <= {sync[1:0], scan_clk};
            // load has priority over a coincident done
            if (load) begin
                shadow    <= value;
                res_valid <= 1'b0;
            end else if (done) begin
                res_valid <= 1'b1;
                res_prime <= is_prime;
            end
            if (tick) begin
                idx     <= next_idx;
                started <= 1'b1;
                frame   <= next_frame;
                an      <= an_hi ^ {DIGITS{SEG_ACTIVE_LOW}};
                seg     <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
                dp      <= dp_hi ^ SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed + random bench for seg_scan_display.
// Two instances (blanking on / off) share stimulus; a digit-level model predicts outputs.
module tb_seg_scan_display;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        scan_clk = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic        is_prime = 1'b0;

    logic [3:0] an_b, an_h;
    logic [6:0] seg_b, seg_h;
    logic       dp_b, dp_h;

    seg_scan_display #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
        .clk_in(clk_in), .rst(rst), .scan_clk(scan_clk), .value(value),
        .load(load), .busy(busy), .done(done), .is_prime(is_prime),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    seg_scan_display #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_h (
        .clk_in(clk_in), .rst(rst), .scan_clk(scan_clk), .value(value),
        .load(load), .busy(busy), .done(done), .is_prime(is_prime),
        .an(an_h), .seg(seg_h), .dp(dp_h)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [6:0] GLY [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    localparam logic [11:0] OFF = 12'hFFF;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: the spec's visible state in plain integers
    logic [15:0] m_shadow, m_frame;
    int          m_idx;
    bit          m_started, m_rv, m_rp;

    task automatic model_reset();
        m_shadow = '0; m_frame = '0; m_idx = 0;
        m_started = 0; m_rv = 0; m_rp = 0;
    endtask

    function automatic logic [11:0] expect_out(input bit blank, input bit bsy);
        logic [15:0] up;
        logic [6:0]  hi;
        logic [3:0]  a;
        logic        d;
        up = m_frame >> (4 * m_idx);
        if (bsy) hi = 7'b1000000;
        else if (blank && m_idx != 0 && up == 16'h0) hi = 7'b0;
        else hi = GLY[up[3:0]];
        d = (m_idx == 0) && m_rv && m_rp && !bsy;
        a = 4'b0001 << m_idx;
        return ~{a, hi, d};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: an/seg/dp got %b_%b_%b expected %b_%b_%b", tag,
                   got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic chk_both(input string tag, input logic [11:0] eb, input logic [11:0] eh);
        chk({tag, "/blank"}, {an_b, seg_b, dp_b}, eb);
        chk({tag, "/hex"}, {an_h, seg_h, dp_h}, eh);
    endtask

    task automatic load_pulse(input logic [15:0] v);
        load = 1'b1; value = v;
        cyc();
        load = 1'b0;
        m_shadow = v; m_rv = 0;
    endtask

    task automatic done_pulse(input bit p, input bit ld, input logic [15:0] v);
        done = 1'b1; is_prime = p; load = ld; value = v;
        cyc();
        done = 1'b0; load = 1'b0;
        if (ld) begin m_shadow = v; m_rv = 0; end
        else begin m_rv = 1; m_rp = p; end
    endtask

    // One scan_clk period; optional load coincident with the tick cycle
    task automatic do_tick(input bit ld, input logic [15:0] v, input string tag);
        logic [11:0] eb, eh;
        int nidx;
        scan_clk = 1'b1;
        cyc();
        cyc();
        if (ld) begin load = 1'b1; value = v; end
        nidx = (!m_started || m_idx == 3) ? 0 : m_idx + 1;
        if (nidx == 0) m_frame = m_shadow;
        m_idx = nidx;
        m_started = 1;
        eb = expect_out(1'b1, busy);
        eh = expect_out(1'b0, busy);
        if (ld) begin m_shadow = v; m_rv = 0; end
        cyc();
        load = 1'b0;
        chk_both(tag, eb, eh);
        scan_clk = 1'b0;
        cyc(); cyc(); cyc();
        chk_both({tag, "_hold"}, eb, eh);
    endtask

    initial begin
        model_reset();
        // Reset held while the scan clock keeps running
        for (int k = 0; k < 8; k++) begin
            scan_clk = ~scan_clk;
            cyc();
        end
        chk_both("reset", OFF, OFF);
        scan_clk = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk_both("post_reset_idle", OFF, OFF);

        do_tick(0, '0, "first_tick");

        load_pulse(16'h12AF);
        for (int k = 0; k < 8; k++) do_tick(0, '0, "hex_12AF");

        load_pulse(16'h0007);
        for (int k = 0; k < 8; k++) do_tick(0, '0, "lz_0007");

        load_pulse(16'h0000);
        for (int k = 0; k < 8; k++) do_tick(0, '0, "lz_0000");

        load_pulse(16'h0300);
        for (int k = 0; k < 8; k++) do_tick(0, '0, "lz_0300");

        // Frame coherence around the wrap
        load_pulse(16'h1234);
        for (int k = 0; k < 4 && m_idx != 1; k++) do_tick(0, '0, "align");
        do_tick(0, '0, "coh_idx2");
        load_pulse(16'h5555);
        do_tick(0, '0, "coh_idx3_old");
        do_tick(1, 16'h9999, "coh_wrap_5555");
        for (int k = 0; k < 3; k++) do_tick(0, '0, "coh_5555");
        for (int k = 0; k < 4; k++) do_tick(0, '0, "coh_9999");

        // Busy and result flag
        busy = 1'b1;
        for (int k = 0; k < 4; k++) do_tick(0, '0, "busy");
        busy = 1'b0;
        done_pulse(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) do_tick(0, '0, "prime_dp");
        load_pulse(16'h0011);
        for (int k = 0; k < 4; k++) do_tick(0, '0, "load_clears_dp");
        done_pulse(1'b1, 1'b1, 16'h0013);
        for (int k = 0; k < 4; k++) do_tick(0, '0, "load_done_same");
        done_pulse(1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) do_tick(0, '0, "not_prime");

        // Random mix
        for (int k = 0; k < 60; k++) begin
            busy = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: load_pulse(16'($urandom) >> (4 * $urandom_range(0, 3)));
                1: done_pulse(1'($urandom), 1'b0, '0);
                2: done_pulse(1'($urandom), 1'b1, 16'($urandom));
                default: ;
            endcase
            do_tick($urandom_range(0, 5) == 0, 16'($urandom), "rand");
        end
        busy = 1'b0;

        // Asynchronous reset between edges while digit 2 is lit
        load_pulse(16'hBEEF);
        for (int k = 0; k < 8 && !(m_idx == 2 && m_frame == 16'hBEEF); k++)
            do_tick(0, '0, "align2");
        @(posedge clk_in);
        #3 rst = 1'b1;
        #1 chk_both("midscan_reset", OFF, OFF);
        model_reset();
        cyc();
        rst = 1'b0;
        cyc();
        chk_both("midscan_idle", OFF, OFF);
        for (int k = 0; k < 4; k++) do_tick(0, '0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
